pengo_input_ctrl: RTL and testbench
===================================

Name: pengo_input_ctrl

Overview:
- Player-input conditioning stage directly upstream of the Pengo core's in0/in1 ports.
- Merges the PS/2 key-event stream and both MiSTer joysticks into the core's two active-low input bytes.
- Enforces 4-way joystick behaviour.
- Stretches coin presses to a whole number of video frames, so the core's once-per-vblank input sampling cannot miss or double-count a coin.

Parameters:
- COIN_FRAMES, 4: number of vblank rising edges a coin line is held asserted; legal range 1..15.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8:0] extended scan code.
- joystick_0  in  16  bit0 right, 1 left, 2 down, 3 up, 4 fire, 5 start1, 6 start2, 7 coin.
- joystick_1  in  16  same layout as joystick_0.
- vblank  in  1  core vertical blank; only its rising edge is used.
- in0  out  8  active-low {fire1, 0, coin1, coin2, right1, left1, down1, up1}.
- in1  out  8  active-low {fire2, start2, start1, 0, right2, left2, down2, up2}.

Behaviour:
- Clock and reset: one clock, clk_sys. reset_n is asynchronous and active-low.
- Reset state:
  - in0 = 8'hFF, in1 = 8'hFF.
  - All key-state registers = 0, toggle-history register = 0, vblank-history register = 0.
  - Both coin FSMs in IDLE, counters 0, pending flags 0.
- Key event detection: an event is accepted on the edge where ps2_key[10] differs from the registered previous value. At that edge the mapped key register loads ps2_key[9].
- Key map (scan code -> key register):
  - X75 up1, X72 down1, X6B left1, X74 right1 (X = don't-care extended bit).
  - 029 or 014 -> fire1.
  - 005 or 016 -> start1; 006 or 01E -> start2.
  - 02E coin1, 036 coin2.
  - 02D up2, 02B down2, 023 left2, 034 right2, 01C fire2.
  - Unmapped codes are ignored.
- Merge: joy = joystick_0 | joystick_1.
  - Raw directions for player 1 = key | joy[3:0]; player 2 directions = P2 key | joy[3:0].
  - fire1 = key | joy[4]; fire2 = key only.
  - start1 = key | joy[5]; start2 = key | joy[6].
  - coin1 request = key | joy[7]; coin2 request = key only.
- 4-way filter, one instance per player, holding a 2-bit registered direction plus a valid flag:
  - If the held direction is still raw-asserted, keep it, even when other directions are also asserted.
  - Otherwise select by priority up > down > left > right.
  - No direction asserted -> output none.
  - Exactly one direction bit is active at the output.
- Coin FSM, one per coin line, advanced by the registered vblank rising edge (vbl_rise):
  - IDLE: request rising edge -> ACTIVE, cnt = 0.
  - ACTIVE: coin asserted. On each vbl_rise, cnt++. The vbl_rise with cnt == COIN_FRAMES-1 moves to GAP.
  - GAP: coin deasserted. The next vbl_rise moves to ACTIVE (cnt = 0, pending cleared) if pending = 1, else to IDLE.
  - A request rising edge in ACTIVE or GAP sets pending; pending saturates at 1, so further presses are dropped.
  - A request rising edge and vbl_rise on the same cycle in IDLE: enter ACTIVE, and that vbl_rise is not counted.
  - A held request does not retrigger; only rising edges count.
- Output register: in0/in1 are registered and are the bitwise inverse of the filtered/stretched active-high values. Constant bits (in0[6], in1[4]) always read 1.
- Latency:
  - Key event presented at edge N -> key register updated at N -> in0/in1 reflect it at edge N+1.
  - Joystick change -> outputs change 1 edge later.
  - vblank rise -> FSM effect 2 edges later (history register, then output register).
- Reset mid-operation: asynchronous return to the reset state. No pending coin survives reset.

Test Plan:
- Reset: hold reset_n = 0 with joysticks all-ones -> in0 = 8'hFF, in1 = 8'hFF; release -> joysticks reflected within 1 cycle.
- Key path: toggle ps2_key = {1,1,9'h075} -> in0 = 8'hFE two edges after presentation; toggle {0,0,9'h075} -> in0 = 8'hFF. Re-presenting the same toggle value changes nothing.
- 4-way filter: joy up held, then add right -> in0[3:0] stays 4'b1110. Release up with right held -> in0[3:0] = 4'b0111. Press up+left together from idle -> up wins (4'b1110).
- Coin stretch (COIN_FRAMES = 4): 1-cycle joy[7] pulse -> in0[5] = 0 for exactly 4 vblank rises, then 1 for one frame, then IDLE.
- Coin pending: a second coin press during ACTIVE -> second 4-frame pulse after a 1-frame gap. A third press in the same window is dropped (exactly 2 pulses total).
- Coin edge cases: coin2 key held for 20 frames -> a single pulse. Assert reset_n = 0 mid-pulse -> in0[4] = 1 immediately, no later pulse.

Source files
------------

// File: rtl/pengo_input_ctrl.sv
// Pengo player-input conditioning: PS/2 + joystick merge, 4-way filter,
// and frame-aligned coin stretching into the core's active-low in0/in1.
module pengo_input_ctrl #(
    parameter int COIN_FRAMES = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        vblank,
    output logic [7:0]  in0,
    output logic [7:0]  in1
);

    typedef enum logic [1:0] {
        C_IDLE,
        C_ACTIVE,
        C_GAP
    } coin_st_t;

    localparam logic [3:0] LAST = 4'(COIN_FRAMES - 1);

    localparam int K_UP1    = 0;
    localparam int K_DOWN1  = 1;
    localparam int K_LEFT1  = 2;
    localparam int K_RIGHT1 = 3;
    localparam int K_FIRE1  = 4;
    localparam int K_START1 = 5;
    localparam int K_START2 = 6;
    localparam int K_COIN1  = 7;
    localparam int K_COIN2  = 8;
    localparam int K_UP2    = 9;
    localparam int K_DOWN2  = 10;
    localparam int K_LEFT2  = 11;
    localparam int K_RIGHT2 = 12;
    localparam int K_FIRE2  = 13;

    logic        tog_q;
    logic        vbl_q;
    logic [13:0] key_q;
    logic [13:0] key_hit;
    logic        evt;
    logic        vbl_rise;

    logic [15:0] joy;
    logic [3:0]  joy_dir;
    logic [3:0]  raw1;
    logic [3:0]  raw2;
    logic [2:0]  sel1;
    logic [2:0]  sel2;
    logic [3:0]  oh1;
    logic [3:0]  oh2;
    logic        hv1;
    logic        hv2;
    logic [1:0]  hd1;
    logic [1:0]  hd2;

    logic        fire1;
    logic        fire2;
    logic        start1;
    logic        start2;

    logic [1:0]  creq;
    logic [1:0]  creq_q;
    logic [1:0]  crise;
    logic [1:0]  cpend;
    logic [1:0]  coin_on;
    coin_st_t    cst  [2];
    logic [3:0]  ccnt [2];

    // Held direction wins while still pressed; else up > down > left > right.
    function automatic logic [2:0] pick(
        input logic [3:0] r,
        input logic       hv,
        input logic [1:0] hd
    );
        if (hv && r[hd]) return {1'b1, hd};
        if (r[0]) return 3'b100;
        if (r[1]) return 3'b101;
        if (r[2]) return 3'b110;
        if (r[3]) return 3'b111;
        return 3'b000;
    endfunction

    function automatic logic [3:0] dec(input logic [2:0] s);
        return s[2] ? (4'b0001 << s[1:0]) : 4'b0000;
    endfunction

    assign evt      = ps2_key[10] != tog_q;
    assign vbl_rise = vblank & ~vbl_q;

    always_comb begin
        key_hit = '0;
        casez (ps2_key[8:0])
            9'b?0111_0101:  key_hit[K_UP1]    = 1'b1;
            9'b?0111_0010:  key_hit[K_DOWN1]  = 1'b1;
            9'b?0110_1011:  key_hit[K_LEFT1]  = 1'b1;
            9'b?0111_0100:  key_hit[K_RIGHT1] = 1'b1;
            9'h029, 9'h014: key_hit[K_FIRE1]  = 1'b1;
            9'h005, 9'h016: key_hit[K_START1] = 1'b1;
            9'h006, 9'h01E: key_hit[K_START2] = 1'b1;
            9'h02E:         key_hit[K_COIN1]  = 1'b1;
            9'h036:         key_hit[K_COIN2]  = 1'b1;
            9'h02D:         key_hit[K_UP2]    = 1'b1;
            9'h02B:         key_hit[K_DOWN2]  = 1'b1;
            9'h023:         key_hit[K_LEFT2]  = 1'b1;
            9'h034:         key_hit[K_RIGHT2] = 1'b1;
            9'h01C:         key_hit[K_FIRE2]  = 1'b1;
            default:        key_hit = '0;
        endcase
    end

    assign joy     = joystick_0 | joystick_1;
    // Reorder joystick {up,down,left,right} into filter order (bit0 = up).
    assign joy_dir = {joy[0], joy[1], joy[2], joy[3]};
    assign raw1    = key_q[K_RIGHT1:K_UP1] | joy_dir;
    assign raw2    = key_q[K_RIGHT2:K_UP2] | joy_dir;
    assign sel1    = pick(raw1, hv1, hd1);
    assign sel2    = pick(raw2, hv2, hd2);
    assign oh1     = dec(sel1);
    assign oh2     = dec(sel2);

    assign fire1  = key_q[K_FIRE1] | joy[4];
    assign fire2  = key_q[K_FIRE2];
    assign start1 = key_q[K_START1] | joy[5];
    assign start2 = key_q[K_START2] | joy[6];

    assign creq  = {key_q[K_COIN2], key_q[K_COIN1] | joy[7]};
    assign crise = creq & ~creq_q;

    always_comb begin
        coin_on = '0;
        for (int i = 0; i < 2; i++) coin_on[i] = cst[i] == C_ACTIVE;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q <= 1'b0;
            vbl_q <= 1'b0;
            key_q <= '0;
            hv1   <= 1'b0;
            hd1   <= 2'd0;
            hv2   <= 1'b0;
            hd2   <= 2'd0;
        end else begin
            tog_q <= ps2_key[10];
            vbl_q <= vblank;
            if (evt) key_q <= (key_q & ~key_hit) | (key_hit & {14{ps2_key[9]}});
            {hv1, hd1} <= sel1;
            {hv2, hd2} <= sel2;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            creq_q <= '0;
            cpend  <= '0;
            for (int i = 0; i < 2; i++) begin
                cst[i]  <= C_IDLE;
                ccnt[i] <= '0;
            end
        end else begin
            creq_q <= creq;
            for (int i = 0; i < 2; i++) begin
                unique case (cst[i])
                    C_IDLE: begin
                        if (crise[i]) begin
                            cst[i]  <= C_ACTIVE;
                            ccnt[i] <= '0;
                        end
                    end
                    C_ACTIVE: begin
                        if (crise[i]) cpend[i] <= 1'b1;
                        if (vbl_rise) begin
                            if (ccnt[i] == LAST) cst[i] <= C_GAP;
                            else ccnt[i] <= ccnt[i] + 4'd1;
                        end
                    end
                    C_GAP: begin
                        if (vbl_rise) begin
                            if (cpend[i] | crise[i]) begin
                                cst[i]   <= C_ACTIVE;
                                ccnt[i]  <= '0;
                                cpend[i] <= 1'b0;
                            end else begin
                                cst[i] <= C_IDLE;
                            end
                        end else if (crise[i]) begin
                            cpend[i] <= 1'b1;
                        end
                    end
                    default: cst[i] <= C_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            in0 <= 8'hFF;
            in1 <= 8'hFF;
        end else begin
            in0 <= ~{fire1, 1'b0, coin_on[0], coin_on[1], oh1};
            in1 <= ~{fire2, start2, start1, 1'b0, oh2};
        end
    end

endmodule

// File: tb/tb_pengo_input_ctrl.sv
// Directed testbench for pengo_input_ctrl.
// Each task drives one scenario and checks in0/in1 against hand-derived values.
module tb_pengo_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic [10:0] ps2_key = '0;
    logic [15:0] joystick_0 = '0;
    logic [15:0] joystick_1 = '0;
    logic        vblank = 1'b0;
    logic [7:0]  in0;
    logic [7:0]  in1;

    int checks = 0;
    int errors = 0;

    pengo_input_ctrl #(.COIN_FRAMES(4)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .vblank     (vblank),
        .in0        (in0),
        .in1        (in1)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic frame();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        ps2_key    = '0;
        joystick_0 = '0;
        joystick_1 = '0;
        vblank     = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2;
        reset_n    = 1'b0;
        joystick_0 = 16'hFFFF;
        joystick_1 = 16'hFFFF;
        tick();
        tick();
        checks++; if (in0 !== 8'hFF) begin errors++; $display("FAIL rst_in0 got=%h exp=%h", in0, 8'hFF); end
        checks++; if (in1 !== 8'hFF) begin errors++; $display("FAIL rst_in1 got=%h exp=%h", in1, 8'hFF); end
        reset_n = 1'b1;
        tick();
        checks++; if (in0 !== 8'h7E) begin errors++; $display("FAIL rel_in0 got=%h exp=%h", in0, 8'h7E); end
        checks++; if (in1 !== 8'h9E) begin errors++; $display("FAIL rel_in1 got=%h exp=%h", in1, 8'h9E); end
    endtask

    task automatic test_key();
        do_reset();
        ps2_key = {1'b1, 1'b1, 9'h075};
        tick();
        checks++; if (in0 !== 8'hFF) begin errors++; $display("FAIL key_lat got=%h exp=%h", in0, 8'hFF); end
        tick();
        checks++; if (in0 !== 8'hFE) begin errors++; $display("FAIL key_up got=%h exp=%h", in0, 8'hFE); end
        ps2_key = {1'b1, 1'b0, 9'h075};
        tick();
        tick();
        checks++; if (in0 !== 8'hFE) begin errors++; $display("FAIL key_same_tog got=%h exp=%h", in0, 8'hFE); end
        ps2_key = {1'b0, 1'b0, 9'h075};
        tick();
        tick();
        checks++; if (in0 !== 8'hFF) begin errors++; $display("FAIL key_rel got=%h exp=%h", in0, 8'hFF); end
        ps2_key = {1'b1, 1'b1, 9'h175};
        tick();
        tick();
        checks++; if (in0 !== 8'hFE) begin errors++; $display("FAIL key_ext_up got=%h exp=%h", in0, 8'hFE); end
        ps2_key = {1'b0, 1'b0, 9'h175};
        tick();
        ps2_key = {1'b1, 1'b1, 9'h029};
        tick();
        tick();
        checks++; if (in0 !== 8'h7F) begin errors++; $display("FAIL key_fire1 got=%h exp=%h", in0, 8'h7F); end
        ps2_key = {1'b0, 1'b0, 9'h029};
        tick();
        ps2_key = {1'b1, 1'b1, 9'h02D};
        tick();
        ps2_key = {1'b0, 1'b1, 9'h006};
        tick();
        tick();
        checks++; if (in0 !== 8'hFF) begin errors++; $display("FAIL key_p2_in0 got=%h exp=%h", in0, 8'hFF); end
        checks++; if (in1 !== 8'hBE) begin errors++; $display("FAIL key_p2_in1 got=%h exp=%h", in1, 8'hBE); end
        ps2_key = {1'b1, 1'b1, 9'h0FF};
        tick();
        tick();
        checks++; if (in1 !== 8'hBE) begin errors++; $display("FAIL key_unmapped got=%h exp=%h", in1, 8'hBE); end
    endtask

    task automatic test_4way();
        do_reset();
        joystick_0 = 16'h0008;
        tick();
        checks++; if (in0 !== 8'hFE) begin errors++; $display("FAIL fw_up got=%h exp=%h", in0, 8'hFE); end
        checks++; if (in1 !== 8'hFE) begin errors++; $display("FAIL fw_up_p2 got=%h exp=%h", in1, 8'hFE); end
        joystick_0 = 16'h0009;
        tick();
        checks++; if (in0 !== 8'hFE) begin errors++; $display("FAIL fw_hold got=%h exp=%h", in0, 8'hFE); end
        joystick_0 = 16'h0001;
        tick();
        checks++; if (in0 !== 8'hF7) begin errors++; $display("FAIL fw_right got=%h exp=%h", in0, 8'hF7); end
        joystick_0 = 16'h0000;
        tick();
        checks++; if (in0 !== 8'hFF) begin errors++; $display("FAIL fw_none got=%h exp=%h", in0, 8'hFF); end
        joystick_0 = 16'h000A;
        tick();
        checks++; if (in0 !== 8'hFE) begin errors++; $display("FAIL fw_upleft got=%h exp=%h", in0, 8'hFE); end
        joystick_0 = 16'h0000;
        joystick_1 = 16'h0004;
        tick();
        checks++; if (in0 !== 8'hFD) begin errors++; $display("FAIL fw_joy1_down got=%h exp=%h", in0, 8'hFD); end
    endtask

    task automatic test_coin_stretch();
        do_reset();
        joystick_0 = 16'h0080;
        tick();
        joystick_0 = 16'h0000;
        tick();
        checks++; if (in0 !== 8'hDF) begin errors++; $display("FAIL coin_start got=%h exp=%h", in0, 8'hDF); end
        for (int f = 1; f <= 6; f++) begin
            logic [7:0] exp;
            frame();
            exp = (f <= 3) ? 8'hDF : 8'hFF;
            checks++; if (in0 !== exp) begin errors++; $display("FAIL coin_frame%0d got=%h exp=%h", f, in0, exp); end
        end
    endtask

    task automatic test_coin_pending();
        do_reset();
        joystick_0 = 16'h0080;
        tick();
        joystick_0 = 16'h0000;
        tick();
        frame();
        joystick_0 = 16'h0080;
        tick();
        joystick_0 = 16'h0000;
        tick();
        joystick_0 = 16'h0080;
        tick();
        joystick_0 = 16'h0000;
        tick();
        checks++; if (in0 !== 8'hDF) begin errors++; $display("FAIL pend_active got=%h exp=%h", in0, 8'hDF); end
        for (int f = 2; f <= 11; f++) begin
            logic [7:0] exp;
            frame();
            exp = (f == 4 || f >= 9) ? 8'hFF : 8'hDF;
            checks++; if (in0 !== exp) begin errors++; $display("FAIL pend_frame%0d got=%h exp=%h", f, in0, exp); end
        end
    endtask

    task automatic test_coin_edges();
        do_reset();
        joystick_0 = 16'h0080;
        vblank     = 1'b1;
        tick();
        joystick_0 = 16'h0000;
        vblank     = 1'b0;
        tick();
        checks++; if (in0 !== 8'hDF) begin errors++; $display("FAIL samecyc_start got=%h exp=%h", in0, 8'hDF); end
        for (int f = 1; f <= 4; f++) begin
            logic [7:0] exp;
            frame();
            exp = (f <= 3) ? 8'hDF : 8'hFF;
            checks++; if (in0 !== exp) begin errors++; $display("FAIL samecyc_frame%0d got=%h exp=%h", f, in0, exp); end
        end

        do_reset();
        ps2_key = {1'b1, 1'b1, 9'h036};
        tick();
        tick();
        tick();
        checks++; if (in0 !== 8'hEF) begin errors++; $display("FAIL held_start got=%h exp=%h", in0, 8'hEF); end
        for (int f = 1; f <= 20; f++) begin
            logic [7:0] exp;
            frame();
            exp = (f <= 3) ? 8'hEF : 8'hFF;
            checks++; if (in0 !== exp) begin errors++; $display("FAIL held_frame%0d got=%h exp=%h", f, in0, exp); end
        end
        ps2_key = {1'b0, 1'b0, 9'h036};
        tick();
        tick();
        ps2_key = {1'b1, 1'b1, 9'h036};
        tick();
        tick();
        tick();
        checks++; if (in0 !== 8'hEF) begin errors++; $display("FAIL mid_start got=%h exp=%h", in0, 8'hEF); end
        frame();
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (in0 !== 8'hFF) begin errors++; $display("FAIL mid_async got=%h exp=%h", in0, 8'hFF); end
        ps2_key = '0;
        tick();
        reset_n = 1'b1;
        for (int f = 1; f <= 6; f++) begin
            frame();
            checks++; if (in0 !== 8'hFF) begin errors++; $display("FAIL mid_after%0d got=%h exp=%h", f, in0, 8'hFF); end
        end
    endtask

    initial begin
        test_reset();
        test_key();
        test_4way();
        test_coin_stretch();
        test_coin_pending();
        test_coin_edges();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
